// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic unit: opcode encodings and sweep FSM states.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_NOT     = 3'd2;
  localparam logic [2:0] OP_NAND    = 3'd3;
  localparam logic [2:0] OP_NOR     = 3'd4;
  localparam logic [2:0] OP_XOR     = 3'd5;
  localparam logic [2:0] OP_XNOR    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  // Highest opcode the sweep generator visits.
  localparam logic [2:0] OP_LAST    = OP_XNOR;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/logic_unit_comb.sv
// Pure combinational bitwise function block.
// Ports:
//   a, b : WIDTH-bit operands (b unused for NOT)
//   op   : function select
//   y    : bitwise result, zero for the illegal opcode
//   err  : high when op is the illegal opcode
module logic_unit_comb
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Registered bitwise logic unit with valid/ready streaming and a built-in
// exhaustive sweep generator.
//
// state | meaning
// IDLE  | external stream accepted through in_valid/in_ready
// SWEEP | internal counters feed every (op, a, b) combination
// DRAIN | last sweep result loaded, waiting for it to be accepted
//
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : external input handshake (a, b, op)
//   mode, start           : start with mode=1 launches a sweep from IDLE
//   out_valid/out_ready   : result handshake (y, out_a, out_b, out_op, out_err)
//   busy                  : sweep in progress (SWEEP or DRAIN)
//   done                  : one-cycle pulse after the last sweep result is taken
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             mode,
  input  logic             start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [2:0]       out_op,
  output logic             out_err,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [2:0]       op_c_q, op_c_d;
  logic [WIDTH-1:0] a_c_q, a_c_d;
  logic [WIDTH-1:0] b_c_q, b_c_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic [2:0]       out_op_q, out_op_d;
  logic             out_err_q, out_err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sweep_active;
  logic             src_valid;
  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] src_a, src_b;
  logic [2:0]       src_op;
  logic [WIDTH-1:0] fn_y;
  logic             fn_err;

  always_comb begin
    sweep_active = (state_q == SWEEP);
    src_valid    = sweep_active || ((state_q == IDLE) && in_valid);
    // Output slot is free when empty or being drained this cycle.
    can_load     = !out_valid_q || out_ready;
    load         = src_valid && can_load;
    src_a        = sweep_active ? a_c_q  : a;
    src_b        = sweep_active ? b_c_q  : b;
    src_op       = sweep_active ? op_c_q : op;
  end

  assign in_ready = (state_q == IDLE) && can_load;

  logic_unit_comb #(.WIDTH(WIDTH)) u_comb (
    .a   (src_a),
    .b   (src_b),
    .op  (src_op),
    .y   (fn_y),
    .err (fn_err)
  );

  always_comb begin
    state_d     = state_q;
    op_c_d      = op_c_q;
    a_c_d       = a_c_q;
    b_c_d       = b_c_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    y_d         = y_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_op_d    = out_op_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;

    if (load) begin
      out_valid_d = 1'b1;
      y_d         = fn_y;
      out_a_d     = src_a;
      out_b_d     = src_b;
      out_op_d    = src_op;
      out_err_d   = fn_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start && mode) begin
          state_d = SWEEP;
          busy_d  = 1'b1;
          op_c_d  = '0;
          a_c_d   = '0;
          b_c_d   = '0;
        end
      end
      SWEEP: begin
        // Counters only advance on a load, so backpressure never skips a combination.
        if (load) begin
          if (b_c_q == CNT_MAX) begin
            b_c_d = '0;
            if (a_c_q == CNT_MAX) begin
              a_c_d = '0;
              if (op_c_q == OP_LAST) begin
                op_c_d  = '0;
                state_d = DRAIN;
              end else begin
                op_c_d = op_c_q + 3'd1;
              end
            end else begin
              a_c_d = a_c_q + WIDTH'(1);
            end
          end else begin
            b_c_d = b_c_q + WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_c_q      <= '0;
      a_c_q       <= '0;
      b_c_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_op_q    <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_c_q      <= op_c_d;
      a_c_q       <= a_c_d;
      b_c_q       <= b_c_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_op_q    <= out_op_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_op    = out_op_q;
  assign out_err   = out_err_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Scoreboard bench: three instances (WIDTH=4 external stream, WIDTH=1 and
// WIDTH=2 sweeps). Expected results are queued per instance; monitors pop and
// compare on every out_valid && out_ready seen at the falling edge.
module tb_logic_unit_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // Packed result: {err, op, a, b, y} with 8-bit operand fields.
  logic [27:0] q4[$];
  logic [27:0] q1[$];
  logic [27:0] q2[$];
  int pops1 = 0, pops2 = 0, pops4 = 0;
  int done_cnt1 = 0, done_cnt2 = 0, done_cnt4 = 0;

  logic       iv4, ir4, mode4, start4, ov4, ord4, oerr4, busy4, done4;
  logic [3:0] a4, b4, y4, oa4, ob4;
  logic [2:0] op4, oop4;

  logic       iv1, ir1, mode1, start1, ov1, ord1, oerr1, busy1, done1;
  logic [0:0] a1, b1, y1, oa1, ob1;
  logic [2:0] op1, oop1;

  logic       iv2, ir2, mode2, start2, ov2, ord2, oerr2, busy2, done2;
  logic [1:0] a2, b2, y2, oa2, ob2;
  logic [2:0] op2, oop2;

  logic_unit_seq #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .op(op4), .mode(mode4), .start(start4), .out_valid(ov4), .out_ready(ord4),
    .y(y4), .out_a(oa4), .out_b(ob4), .out_op(oop4), .out_err(oerr4),
    .busy(busy4), .done(done4));

  logic_unit_seq #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .op(op1), .mode(mode1), .start(start1), .out_valid(ov1), .out_ready(ord1),
    .y(y1), .out_a(oa1), .out_b(ob1), .out_op(oop1), .out_err(oerr1),
    .busy(busy1), .done(done1));

  logic_unit_seq #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .op(op2), .mode(mode2), .start(start2), .out_valid(ov2), .out_ready(ord2),
    .y(y2), .out_a(oa2), .out_b(ob2), .out_op(oop2), .out_err(oerr2),
    .busy(busy2), .done(done2));

  function automatic logic [27:0] pack(input logic err, input logic [2:0] op,
                                       input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] y);
    return {err, op, a, b, y};
  endfunction

  // Two-input gate truth tables, bit index = {a, b}.
  function automatic logic tt_bit(input logic [2:0] op, input logic ab, input logic bb);
    logic [3:0] t;
    case (op)
      3'd0:    t = 4'b1000;
      3'd1:    t = 4'b1110;
      3'd2:    t = 4'b0011;
      3'd3:    t = 4'b0111;
      3'd4:    t = 4'b0001;
      3'd5:    t = 4'b0110;
      3'd6:    t = 4'b1001;
      default: t = 4'b0000;
    endcase
    return t[{ab, bb}];
  endfunction

  function automatic logic [7:0] model_y(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input int w);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = tt_bit(op, a[i], b[i]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_sweep(input int w);
    for (int o = 0; o < 7; o++)
      for (int ai = 0; ai < (1 << w); ai++)
        for (int bi = 0; bi < (1 << w); bi++) begin
          logic [27:0] e;
          e = pack(1'b0, 3'(o), 8'(ai), 8'(bi), model_y(3'(o), 8'(ai), 8'(bi), w));
          if (w == 1) q1.push_back(e); else q2.push_back(e);
        end
  endtask

  // Monitors
  always @(negedge clk) begin
    if (rst_n && ov4 && ord4) begin
      pops4++;
      if (q4.size() == 0) chk("unexpected_w4", {4'h0, pack(oerr4, oop4, 8'(oa4), 8'(ob4), 8'(y4))}, 32'hFFFF_FFFF);
      else chk("res_w4", {4'h0, pack(oerr4, oop4, 8'(oa4), 8'(ob4), 8'(y4))}, {4'h0, q4.pop_front()});
    end
    if (rst_n && ov1 && ord1) begin
      pops1++;
      if (q1.size() == 0) chk("unexpected_w1", {4'h0, pack(oerr1, oop1, 8'(oa1), 8'(ob1), 8'(y1))}, 32'hFFFF_FFFF);
      else chk("res_w1", {4'h0, pack(oerr1, oop1, 8'(oa1), 8'(ob1), 8'(y1))}, {4'h0, q1.pop_front()});
    end
    if (rst_n && ov2 && ord2) begin
      pops2++;
      if (q2.size() == 0) chk("unexpected_w2", {4'h0, pack(oerr2, oop2, 8'(oa2), 8'(ob2), 8'(y2))}, 32'hFFFF_FFFF);
      else chk("res_w2", {4'h0, pack(oerr2, oop2, 8'(oa2), 8'(ob2), 8'(y2))}, {4'h0, q2.pop_front()});
    end
    if (rst_n && done4) done_cnt4++;
    if (rst_n && done1) done_cnt1++;
    if (rst_n && done2) done_cnt2++;
  end

  // Drive one external input on the WIDTH=4 unit; expectation is hand supplied.
  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                       input logic [3:0] ey, input logic ee);
    bit ok;
    ok  = 1'b0;
    iv4 = 1'b1; a4 = a; b4 = b; op4 = op;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (ir4) begin
        q4.push_back(pack(ee, op, 8'(a), 8'(b), 8'(ey)));
        ok = 1'b1;
      end
    end
    if (!ok) chk("send4_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk); #1;
      chk("latency_w4", 32'(ov4), 32'd1);
    end
  endtask

  task automatic wait_idle(input int w, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (w == 1) ok = !busy1; else ok = !busy2;
    end
    if (!ok) chk("sweep_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int base, dc;
    bit hit;
    rst_n = 1'b0;
    iv4 = 0; a4 = 0; b4 = 0; op4 = 0; mode4 = 0; start4 = 0; ord4 = 1;
    iv1 = 0; a1 = 0; b1 = 0; op1 = 0; mode1 = 0; start1 = 0; ord1 = 1;
    iv2 = 0; a2 = 0; b2 = 0; op2 = 0; mode2 = 0; start2 = 0; ord2 = 1;
    #12;
    chk("rst_out_valid", 32'(ov4), 32'd0);
    chk("rst_y", 32'(y4), 32'd0);
    chk("rst_out_op", 32'(oop4), 32'd0);
    chk("rst_out_err", 32'(oerr4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(ir4), 32'd1);

    // Every opcode on a=1100, b=1010, full throughput.
    send4(4'b1100, 4'b1010, 3'd0, 4'b1000, 1'b0);
    send4(4'b1100, 4'b1010, 3'd1, 4'b1110, 1'b0);
    send4(4'b1100, 4'b1010, 3'd2, 4'b0011, 1'b0);
    send4(4'b1100, 4'b1010, 3'd3, 4'b0111, 1'b0);
    send4(4'b1100, 4'b1010, 3'd4, 4'b0001, 1'b0);
    send4(4'b1100, 4'b1010, 3'd5, 4'b0110, 1'b0);
    send4(4'b1100, 4'b1010, 3'd6, 4'b1001, 1'b0);
    send4(4'hF, 4'hF, 3'd7, 4'h0, 1'b1);
    iv4 = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("drained_w4", 32'(ov4), 32'd0);

    // Backpressure: the held result must not move while out_ready is low.
    ord4 = 1'b0;
    send4(4'h3, 4'h5, 3'd0, 4'h1, 1'b0);
    iv4 = 1'b1; a4 = 4'h3; b4 = 4'h5; op4 = 3'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(ov4), 32'd1);
      chk("bp_y_stable", 32'(y4), 32'h1);
      chk("bp_in_ready", 32'(ir4), 32'd0);
    end
    @(posedge clk); #1;
    ord4 = 1'b1;
    send4(4'h3, 4'h5, 3'd5, 4'h6, 1'b0);
    iv4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("w4_queue_empty", 32'(q4.size()), 32'd0);
    chk("w4_result_count", 32'(pops4), 32'd10);

    // WIDTH=1 sweep, no backpressure.
    push_sweep(1);
    @(posedge clk); #1;
    mode1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; mode1 = 1'b0;
    chk("w1_busy", 32'(busy1), 32'd1);
    chk("w1_in_ready", 32'(ir1), 32'd0);
    wait_idle(1, 200);
    chk("w1_done_once", 32'(done_cnt1), 32'd1);
    chk("w1_count", 32'(pops1), 32'd28);
    chk("w1_queue_empty", 32'(q1.size()), 32'd0);
    chk("w1_busy_after", 32'(busy1), 32'd0);

    // WIDTH=2 sweep, random backpressure, ignored mid-sweep start.
    push_sweep(2);
    @(posedge clk); #1;
    mode2 = 1'b1; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0; mode2 = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(posedge clk); #1;
      ord2   = 1'($urandom_range(0, 1));
      start2 = (i == 30);
      mode2  = (i == 30) || (i == 40);
      hit    = !busy2;
    end
    start2 = 1'b0; mode2 = 1'b0; ord2 = 1'b1;
    if (!hit) chk("w2_sweep_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    chk("w2_done_once", 32'(done_cnt2), 32'd1);
    chk("w2_count", 32'(pops2), 32'd112);
    chk("w2_queue_empty", 32'(q2.size()), 32'd0);

    // Reset in the middle of a sweep, then restart from the beginning.
    base = pops2;
    dc   = done_cnt2;
    push_sweep(2);
    @(posedge clk); #1;
    mode2 = 1'b1; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0; mode2 = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk); #1;
      hit = (pops2 >= base + 9);
    end
    if (!hit) chk("w2_reset_wait_timeout", 32'd0, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(ov2), 32'd0);
    chk("async_rst_busy", 32'(busy2), 32'd0);
    q2.delete();
    @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt2), 32'(dc));
    chk("rst_idle_out_valid", 32'(ov2), 32'd0);

    base = pops2;
    push_sweep(2);
    @(posedge clk); #1;
    mode2 = 1'b1; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0; mode2 = 1'b0;
    wait_idle(2, 400);
    chk("restart_done", 32'(done_cnt2), 32'(dc + 1));
    chk("restart_count", 32'(pops2 - base), 32'd112);
    chk("restart_queue_empty", 32'(q2.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_unit_seq.md
Name: logic_unit_seq

Overview:
Registered, parametrised bitwise logic unit: an N-bit successor to the 2-input basic gate block. It computes AND, OR, NOT, NAND, NOR, XOR or XNOR on two WIDTH-bit operands, selected by opcode, with a valid/ready stream interface. A built-in sweep mode generates every opcode and operand combination, so downstream checkers and benches get exhaustive coverage without an external stimulus source.

Parameters:
WIDTH, 4, operand/result width in bits; legal range 1..8 (the sweep length is 7*2^(2*WIDTH)).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  external operand/opcode valid
in_ready  output  1  unit accepts external input this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  function select (encodings below)
mode  input  1  0 = external stream, 1 = sweep; sampled only on start
start  input  1  begin sweep (ignored unless idle and mode=1)
out_valid  output  1  result register holds valid data
out_ready  input  1  downstream accepts result
y  output  WIDTH  result
out_a  output  WIDTH  operand A that produced y
out_b  output  WIDTH  operand B that produced y
out_op  output  3  opcode that produced y
out_err  output  1  opcode was illegal (7)
busy  output  1  sweep in progress
done  output  1  one-cycle pulse when the last sweep result is accepted

Behaviour:
- Reset (async assert, sync deassert at the flop level): out_valid=0, y/out_a/out_b/out_op=0, out_err=0, busy=0, done=0, FSM in IDLE, sweep counters=0.
- Opcodes: 0 AND, 1 OR, 2 NOT a (b ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 illegal: y=0, out_err=1. All operations are bitwise over WIDTH.
- Output register: load when the source is valid and (!out_valid || out_ready). Latency is 1 cycle from the accepted input to out_valid.
- out_valid rules:
  - It clears on out_ready when no new load occurs.
  - Simultaneous accept and load keeps out_valid=1 and replaces the data, giving full throughput of 1 result per cycle.
- Output stability: while out_valid=1 and out_ready=0, y and out_* hold stable.
- in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational from state and out_ready.
- FSM states:
  - IDLE: external stream active. start=1 with mode=1 goes to SWEEP and clears the counters (op_c=0, a_c=0, b_c=0).
  - SWEEP: busy=1, in_ready=0, in_valid ignored. The source is valid every cycle with (op_c, a_c, b_c). On each load, b_c increments; at b_c wrap, a_c increments; at a_c wrap, op_c increments. op_c covers 0..6 only.
  - SWEEP, last combination: when the load of (6, max, max) occurs, go to DRAIN.
  - DRAIN: wait for the final result to be accepted. On out_valid && out_ready, pulse done=1 and return to IDLE with busy=0.
- Backpressure: out_ready=0 freezes the counters, so no combination is skipped or repeated.
- start is ignored while busy, or when mode=0. A mode change mid-sweep has no effect.
- An external input pending at sweep start is not accepted, because in_ready=0.
- Reset mid-sweep: immediately return to IDLE; out_valid=0, busy=0, no done pulse.
- WIDTH=1: 4 pairs per opcode, 28 results total.

Decomposition:
- Package logic_unit_pkg: opcode localparams (OP_AND..OP_XNOR, OP_ILLEGAL=7), OP_LAST=6, FSM state encoding (IDLE, SWEEP, DRAIN).
- Sub-module logic_unit_comb: pure combinational function, with inputs a, b, op and outputs y, err. It is instantiated once, with the mux selecting between external inputs and sweep counters in front of it.

Test Plan:
1. Reset, WIDTH=4, in_valid=1, a=4'b1100, b=4'b1010, op sequence 0..6, out_ready=1 -> y: 1000, 1110, 0011, 0111, 0001, 0110, 1001 on consecutive cycles, each 1 cycle after input, out_err=0.
2. op=7, a=4'hF, b=4'hF -> y=0, out_err=1, out_op=7.
3. Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> out_valid=1, y stable, in_ready=0. Release -> the next input loads the same cycle, with no input lost or duplicated.
4. WIDTH=1 sweep, out_ready=1: start with mode=1 -> 28 results in order (op, a, b) = (0,0,0), (0,0,1), (0,1,0), (0,1,1), (1,0,0) ... (6,1,1), matching the 2-input gate truth tables. done pulses once on the 28th accept; busy=0 after.
5. WIDTH=2 sweep with random out_ready (about 50%) -> exactly 112 results, none skipped or repeated, one done pulse. start asserted mid-sweep is ignored.
6. Assert rst_n=0 during sweep result 10 -> out_valid=0 and busy=0 asynchronously, no done pulse. A new start then sweeps from (0,0,0).
